// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter and its grant logic: FSM encoding, size limits,
// and the default word/opcode widths that alu_top uses as well.
package alu_arbiter_pkg;

   localparam int unsigned MAX_REQ          = 8;
   localparam int unsigned DEF_WORD_SIZE    = 32;
   localparam int unsigned DEF_ALU_CON_SIZE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Width of a requester index; at least one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// rr_grant: combinational grant picker for alu_arbiter. Round-robin from ptr+1 by default;
// defining ALU_ARBITER_FIXED_PRIO_EN selects fixed priority (lowest index wins, ptr ignored).
module rr_grant
   import alu_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IW-1:0]      o_idx
);

`ifdef ALU_ARBITER_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      logic w_found;
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!w_found && i_req[i[IW-1:0]]) begin
            w_found                = 1'b1;
            o_grant[i[IW-1:0]]     = 1'b1;
            o_idx                  = i[IW-1:0];
         end
      end
   end
`else
   always_comb begin
      logic        w_found;
      int unsigned w_j;
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      // Scan starts one past the last winner and wraps, so the last winner is checked last.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_j = (32'(i_ptr) + k) % NUM_REQ;
         if (!w_found && i_req[w_j[IW-1:0]]) begin
            w_found                = 1'b1;
            o_grant[w_j[IW-1:0]]   = 1'b1;
            o_idx                  = w_j[IW-1:0];
         end
      end
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu_top among NUM_REQ requesters (IDLE -> WAIT -> RESP -> IDLE).
// Build option: ALU_ARBITER_FIXED_PRIO_EN switches round-robin to fixed lowest-index priority.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
   parameter int unsigned ALU_CON_SIZE = DEF_ALU_CON_SIZE,
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned ALU_LAT      = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*ALU_CON_SIZE-1:0] req_con,
   input  logic [NUM_REQ*WORD_SIZE-1:0]    req_a,
   input  logic [NUM_REQ*WORD_SIZE-1:0]    req_b,
   output logic [NUM_REQ-1:0]              rsp_valid,
   input  logic [NUM_REQ-1:0]              rsp_ready,
   output logic [WORD_SIZE-1:0]            rsp_data,
   output logic [ALU_CON_SIZE-1:0]         alu_con,
   output logic [WORD_SIZE-1:0]            alu_in_1,
   output logic [WORD_SIZE-1:0]            alu_in_2,
   input  logic [WORD_SIZE-1:0]            alu_out,
   output logic                            busy
);

   localparam int unsigned IW = idx_width(NUM_REQ);
   localparam int unsigned CW = $clog2(ALU_LAT + 1);

   arb_state_e               r_state;
   arb_state_e               w_next_state;
   logic [IW-1:0]            r_ptr;
   logic [IW-1:0]            r_gnt;
   logic [CW-1:0]            r_cnt;
   logic [ALU_CON_SIZE-1:0]  r_alu_con;
   logic [WORD_SIZE-1:0]     r_alu_in_1;
   logic [WORD_SIZE-1:0]     r_alu_in_2;
   logic [WORD_SIZE-1:0]     r_rsp_data;
   logic [NUM_REQ-1:0]       w_grant;
   logic [IW-1:0]            w_idx;
   logic                     w_take;

   rr_grant #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_grant (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   // No handshake is offered while reset is held, even though the state already reads IDLE.
   always_comb begin
      w_next_state = r_state;
      req_ready    = '0;
      rsp_valid    = '0;
      w_take       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!rst && (|w_grant)) begin
               req_ready    = w_grant;
               w_take       = 1'b1;
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == '0) w_next_state = RESP;
         end
         RESP: begin
            rsp_valid[r_gnt] = 1'b1;
            if (rsp_ready[r_gnt]) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // WAIT runs ALU_LAT+1 cycles (cnt ALU_LAT..0): one to present operands, ALU_LAT for alu_top.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ptr      <= IW'(NUM_REQ - 1);
         r_gnt      <= '0;
         r_cnt      <= '0;
         r_alu_con  <= '0;
         r_alu_in_1 <= '0;
         r_alu_in_2 <= '0;
         r_rsp_data <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (w_take) begin
                  r_gnt      <= w_idx;
                  r_cnt      <= CW'(ALU_LAT);
                  r_alu_con  <= req_con[w_idx*ALU_CON_SIZE +: ALU_CON_SIZE];
                  r_alu_in_1 <= req_a[w_idx*WORD_SIZE +: WORD_SIZE];
                  r_alu_in_2 <= req_b[w_idx*WORD_SIZE +: WORD_SIZE];
               end
            end
            WAIT: begin
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               else             r_rsp_data <= alu_out;
            end
            RESP: begin
               if (rsp_ready[r_gnt]) r_ptr <= r_gnt;
            end
            default: ;
         endcase
      end
   end

   assign alu_con  = r_alu_con;
   assign alu_in_1 = r_alu_in_1;
   assign alu_in_2 = r_alu_in_2;
   assign rsp_data = r_rsp_data;
   assign busy     = (r_state != IDLE);

endmodule
